bright_spot_tracker: RTL

BRIGHT_SPOT_TRACKER -- requirements
Module: bright_spot_tracker

---
 rtl/bright_spot_tracker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bright_spot_tracker.sv
// rtl/bright_spot_tracker.sv - per-frame bright-pixel bounding box with SEARCH/LOCKED/COAST lock tracking
// Results of the frame just closed are published one cycle after frame_start and held until the next one.
module bright_spot_tracker #(
  parameter logic [9:0] THRESH      = 10'd1000,
  parameter int         MIN_COUNT   = 16,
  parameter int         HOLD_FRAMES = 8,
  parameter logic [9:0] HOME_X      = 10'd464,
  parameter logic [9:0] HOME_Y      = 10'd274
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  VGA_X,
  input  logic [9:0]  VGA_Y,
  input  logic [9:0]  VGA_R_In,
  input  logic [9:0]  VGA_G_In,
  input  logic [9:0]  VGA_B_In,
  input  logic        track_en,
  output logic [9:0]  center_x,
  output logic [9:0]  center_y,
  output logic        locked,
  output logic [18:0] hit_count,
  output logic        frame_done
);

  typedef enum logic [1:0] {SEARCH, LOCKED, COAST} state_t;

  localparam logic [18:0] MIN_CNT  = 19'(MIN_COUNT);
  localparam logic [4:0]  HOLD_CNT = 5'(HOLD_FRAMES);
  localparam logic [18:0] CNT_MAX  = 19'h7FFFF;

  state_t      state_q, state_d;
  logic [3:0]  miss_q, miss_d;
  logic [18:0] cnt_q, cnt_d;
  logic [9:0]  min_x_q, min_x_d, max_x_q, max_x_d;
  logic [9:0]  min_y_q, min_y_d, max_y_q, max_y_d;
  logic [9:0]  center_x_q, center_x_d, center_y_q, center_y_d;
  logic [18:0] hit_count_q, hit_count_d;
  logic        locked_q, locked_d;
  logic        frame_done_q, frame_done_d;

  logic        bright;
  logic        good;
  logic [10:0] sum_x, sum_y;
  logic [9:0]  cand_x, cand_y;
  logic [4:0]  miss_inc;

  always_comb begin
    bright   = pix_valid & track_en & (VGA_R_In >= THRESH) &
               (VGA_G_In >= THRESH) & (VGA_B_In >= THRESH);
    good     = (cnt_q >= MIN_CNT);
    sum_x    = {1'b0, min_x_q} + {1'b0, max_x_q};
    sum_y    = {1'b0, min_y_q} + {1'b0, max_y_q};
    cand_x   = sum_x[10:1];
    cand_y   = sum_y[10:1];
    miss_inc = {1'b0, miss_q} + 5'd1;

    state_d      = state_q;
    miss_d       = miss_q;
    cnt_d        = cnt_q;
    min_x_d      = min_x_q;
    max_x_d      = max_x_q;
    min_y_d      = min_y_q;
    max_y_d      = max_y_q;
    center_x_d   = center_x_q;
    center_y_d   = center_y_q;
    hit_count_d  = hit_count_q;
    frame_done_d = 1'b0;

    if (frame_start) begin
      frame_done_d = 1'b1;
      hit_count_d  = cnt_q;
      case (state_q)
        SEARCH: begin
          if (good) begin
            state_d    = LOCKED;
            center_x_d = cand_x;
            center_y_d = cand_y;
          end else begin
            center_x_d = HOME_X;
            center_y_d = HOME_Y;
          end
        end
        LOCKED: begin
          if (good) begin
            center_x_d = cand_x;
            center_y_d = cand_y;
          end else begin
            state_d = COAST;
            miss_d  = 4'd1;
          end
        end
        COAST: begin
          if (good) begin
            state_d    = LOCKED;
            miss_d     = 4'd0;
            center_x_d = cand_x;
            center_y_d = cand_y;
          end else if (miss_inc == HOLD_CNT) begin
            state_d    = SEARCH;
            miss_d     = 4'd0;
            center_x_d = HOME_X;
            center_y_d = HOME_Y;
          end else begin
            miss_d = miss_inc[3:0];
          end
        end
        default: state_d = SEARCH;
      endcase

      // A bright pixel on the frame_start cycle opens the new frame.
      if (bright) begin
        cnt_d   = 19'd1;
        min_x_d = VGA_X;
        max_x_d = VGA_X;
        min_y_d = VGA_Y;
        max_y_d = VGA_Y;
      end else begin
        cnt_d   = 19'd0;
        min_x_d = 10'h3FF;
        max_x_d = 10'h000;
        min_y_d = 10'h3FF;
        max_y_d = 10'h000;
      end
    end else if (bright) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 19'd1;
      if (VGA_X < min_x_q) min_x_d = VGA_X;
      if (VGA_X > max_x_q) max_x_d = VGA_X;
      if (VGA_Y < min_y_q) min_y_d = VGA_Y;
      if (VGA_Y > max_y_q) max_y_d = VGA_Y;
    end

    locked_d = (state_d != SEARCH);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= SEARCH;
      miss_q       <= 4'd0;
      cnt_q        <= 19'd0;
      min_x_q      <= 10'h3FF;
      max_x_q      <= 10'h000;
      min_y_q      <= 10'h3FF;
      max_y_q      <= 10'h000;
      center_x_q   <= HOME_X;
      center_y_q   <= HOME_Y;
      hit_count_q  <= 19'd0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_q       <= miss_d;
      cnt_q        <= cnt_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      center_x_q   <= center_x_d;
      center_y_q   <= center_y_d;
      hit_count_q  <= hit_count_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign center_x   = center_x_q;
  assign center_y   = center_y_q;
  assign locked     = locked_q;
  assign hit_count  = hit_count_q;
  assign frame_done = frame_done_q;

endmodule
